// File: rtl/zx_bus_pkg.sv
// Shared Z80 bus definitions for the Spectrum bank mapper: bus-cycle decode,
// memory regions, fixed banks, IO port constants and paging-register fields.
package zx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    IO_RD,
    IO_WR
  } bus_cycle_e;

  localparam logic [1:0] REGION_ROM   = 2'd0;
  localparam logic [1:0] REGION_LOW   = 2'd1;
  localparam logic [1:0] REGION_MID   = 2'd2;
  localparam logic [1:0] REGION_PAGED = 2'd3;

  localparam int unsigned BANK_LOW = 5;
  localparam int unsigned BANK_MID = 2;

  // 0x7FFD is only partially decoded: A[15]=0 and A[1]=0 select it.
  localparam logic [15:0] PAGE_PORT_MASK = 16'h8002;
  localparam logic [7:0]  KEMPSTON_PORT  = 8'h1F;

  localparam int unsigned PG_BANK_LSB = 0;
  localparam int unsigned PG_SCREEN   = 3;
  localparam int unsigned PG_ROM      = 4;
  localparam int unsigned PG_LOCK     = 5;
  localparam int unsigned PG_BANK3    = 6;
  localparam int unsigned PG_BANK4    = 7;

  function automatic bus_cycle_e bus_decode(input logic n_iorq, input logic n_rd,
                                            input logic n_wr);
    bus_cycle_e cyc;
    cyc = IDLE;
    case ({n_iorq, n_rd, n_wr})
      3'b101:  cyc = MEM_RD;
      3'b110:  cyc = MEM_WR;
      3'b001:  cyc = IO_RD;
      3'b010:  cyc = IO_WR;
      default: cyc = IDLE;
    endcase
    return cyc;
  endfunction

endpackage

// File: rtl/zx_debounce.sv
// Per-line 2-flop synchroniser plus stability counter; a line's filtered value
// follows the synchronised value only after DEBOUNCE_CYCLES cycles of disagreement.
module zx_debounce #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_filt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_filt;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/zx_bank_mapper.sv
// 128K-style bank mapper: 0x7FFD paging, bank-extended addresses, chip selects
// and CPU read mux. Define ZX_KEMPSTON_EN to include the debounced port 0x1F.
module zx_bank_mapper
  import zx_bus_pkg::*;
#(
  parameter int unsigned RAM_BANKS       = 8,
  parameter int unsigned ROM_BANKS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 64,
  localparam int unsigned BANK_W         = $clog2(RAM_BANKS)
) (
  input  logic               clk_cpu,
  input  logic               reset,
  input  logic [15:0]        A,
  input  logic [7:0]         D_in,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  input  logic [7:0]         rom_q,
  input  logic [7:0]         ram_q,
  input  logic [7:0]         ula_data,
  input  logic [4:0]         kempston,
  output logic [13+BANK_W:0] mem_addr,
  output logic               rom_cs,
  output logic               ram_cs,
  output logic               ram_we,
  output logic               screen_bank7,
  output logic [7:0]         bus_data,
  output logic               bus_oe,
  output logic               page_locked
);

  bus_cycle_e        w_cyc;
  logic [1:0]        w_region;
  logic              w_is_rom;
  logic              w_mem;
  logic              w_port_wr;
  logic [4:0]        w_bank_full;
  logic              w_rom_bank;
  logic [BANK_W-1:0] w_bank;
  logic [4:0]        w_joy;

  logic [BANK_W-1:0] r_page_bank;
  logic              r_screen;
  logic              r_rom_sel;
  logic              r_locked;
  logic              r_wr_prev;

  assign w_cyc     = bus_decode(nIORQ, nRD, nWR);
  assign w_region  = A[15:14];
  assign w_is_rom  = (w_region == REGION_ROM);
  assign w_mem     = (w_cyc == MEM_RD) || (w_cyc == MEM_WR);
  assign w_port_wr = (w_cyc == IO_WR) && ((A & PAGE_PORT_MASK) == 16'h0000);

  // Bank bits 3/4 live in D[6]/D[7]; the cast drops those a smaller RAM ignores.
  assign w_bank_full = {D_in[PG_BANK4], D_in[PG_BANK3], D_in[PG_BANK_LSB +: 3]};

  // Paging register: only the rising edge of the port-write condition updates it.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_page_bank <= '0;
      r_screen    <= 1'b0;
      r_rom_sel   <= 1'b0;
      r_locked    <= 1'b0;
      r_wr_prev   <= 1'b0;
    end else begin
      r_wr_prev <= w_port_wr;
      if (w_port_wr && !r_wr_prev && !r_locked) begin
        r_page_bank <= BANK_W'(w_bank_full);
        r_screen    <= D_in[PG_SCREEN];
        r_rom_sel   <= D_in[PG_ROM];
        r_locked    <= D_in[PG_LOCK];
      end
    end
  end

  assign w_rom_bank = (ROM_BANKS > 1) ? r_rom_sel : 1'b0;

  always_comb begin
    w_bank = r_page_bank;
    unique case (w_region)
      REGION_ROM: w_bank = BANK_W'(w_rom_bank);
      REGION_LOW: w_bank = BANK_W'(BANK_LOW);
      REGION_MID: w_bank = BANK_W'(BANK_MID);
      default:    w_bank = r_page_bank;
    endcase
  end

  assign mem_addr     = {w_bank, A[13:0]};
  assign rom_cs       = w_mem && w_is_rom;
  assign ram_cs       = w_mem && !w_is_rom;
  assign ram_we       = (w_cyc == MEM_WR) && !w_is_rom;
  assign screen_bank7 = r_screen;
  assign page_locked  = r_locked;

`ifdef ZX_KEMPSTON_EN
  zx_debounce #(
    .WIDTH           (5),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_joy (
    .i_clk  (clk_cpu),
    .i_rst  (reset),
    .i_raw  (~kempston),
    .o_filt (w_joy)
  );
`else
  logic w_unused_kempston;
  assign w_unused_kempston = ^{kempston, DEBOUNCE_CYCLES[0]};
  assign w_joy = 5'b0;
`endif

  always_comb begin
    bus_data = 8'hFF;
    bus_oe   = 1'b0;
    if (w_cyc == MEM_RD) begin
      bus_oe   = 1'b1;
      bus_data = w_is_rom ? rom_q : ram_q;
    end else if (w_cyc == IO_RD) begin
      bus_oe   = 1'b1;
      bus_data = ula_data;
`ifdef ZX_KEMPSTON_EN
      if (A[7:0] == KEMPSTON_PORT) bus_data = {3'b000, w_joy};
`endif
    end
  end

endmodule

// File: tb/tb_zx_bank_mapper.sv
// Self-checking bench for zx_bank_mapper: an 8-bank/1-ROM and a 32-bank/2-ROM
// instance share one bus and are checked against a behavioural paging model.
module tb_zx_bank_mapper;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic        nIORQ, nRD, nWR;
  logic [7:0]  rom_q, ram_q, ula_data;
  logic [4:0]  kempston;

  logic [16:0] a8;
  logic [18:0] a32;
  logic rcs8, mcs8, we8, scr8, oe8, lk8;
  logic rcs32, mcs32, we32, scr32, oe32, lk32;
  logic [7:0] bd8, bd32;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_pg;
  bit         m_lock;
  bit         m_prev;

  always #5 clk_cpu = ~clk_cpu;

  zx_bank_mapper #(.RAM_BANKS(8), .ROM_BANKS(1), .DEBOUNCE_CYCLES(64)) dut8 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D_in(D_in), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .rom_q(rom_q), .ram_q(ram_q), .ula_data(ula_data), .kempston(kempston),
    .mem_addr(a8), .rom_cs(rcs8), .ram_cs(mcs8), .ram_we(we8), .screen_bank7(scr8),
    .bus_data(bd8), .bus_oe(oe8), .page_locked(lk8));

  zx_bank_mapper #(.RAM_BANKS(32), .ROM_BANKS(2), .DEBOUNCE_CYCLES(64)) dut32 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D_in(D_in), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .rom_q(rom_q), .ram_q(ram_q), .ula_data(ula_data), .kempston(kempston),
    .mem_addr(a32), .rom_cs(rcs32), .ram_cs(mcs32), .ram_we(we32), .screen_bank7(scr32),
    .bus_data(bd32), .bus_oe(oe32), .page_locked(lk32));

  task automatic idle();
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic drive(input logic [2:0] strobes, input logic [15:0] addr,
                       input logic [7:0] data);
    {nIORQ, nRD, nWR} = strobes;
    A        = addr;
    D_in     = data;
    rom_q    = 8'($urandom);
    ram_q    = 8'($urandom);
    ula_data = 8'($urandom);
  endtask

  function automatic bit is_page_port(input logic [15:0] addr);
    return (addr[15] == 1'b0) && (addr[1] == 1'b0);
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [7:0] data);
    if (is_page_port(addr) && !m_lock) begin
      m_pg   = data;
      m_lock = data[5];
    end
  endfunction

  // Expected full memory address: 16K bank number times 16384 plus offset.
  function automatic int exp_addr(input int banks, input int roms, input logic [15:0] addr);
    int bank;
    case (addr[15:14])
      2'd0:    bank = (roms == 2) ? int'(m_pg[4]) : 0;
      2'd1:    bank = 5;
      2'd2:    bank = 2;
      default: bank = (int'(m_pg[7]) * 16 + int'(m_pg[6]) * 8 + int'(m_pg[2:0])) % banks;
    endcase
    return bank * 16384 + int'(addr[13:0]);
  endfunction

  task automatic page_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    @(negedge clk_cpu);
    drive(3'b010, addr, data);
    @(posedge clk_cpu);
    model_write(addr, data);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk_cpu);
      D_in = ~data;
      @(posedge clk_cpu);
    end
    @(negedge clk_cpu);
    idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk_cpu);
    reset = 1'b1;
    m_pg = 8'h00; m_lock = 1'b0; m_prev = 1'b0;
    @(negedge clk_cpu);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    A = 16'hC000;
    repeat (3) @(posedge clk_cpu);
    #1;
    n_cmp++; if (lk8 !== 1'b0 || lk32 !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b/%b want 0", lk8, lk32); end
    n_cmp++; if (a32 !== 19'h00000) begin n_err++; $display("FAIL reset_page_addr32: got %h want 00000", a32); end
    n_cmp++; if (bd32 !== 8'hFF || oe32 !== 1'b0) begin n_err++; $display("FAIL reset_idle_bus: got %h/%b want ff/0", bd32, oe32); end
    @(negedge clk_cpu);
    reset = 1'b0;
    @(negedge clk_cpu);
    drive(3'b101, 16'hC123, 8'h00);
    #1;
    n_cmp++; if (a8 !== 17'h00123 || a32 !== 19'h00123) begin n_err++; $display("FAIL rd_c123_addr: got %h/%h want 00123", a8, a32); end
    n_cmp++; if (mcs8 !== 1'b1 || rcs8 !== 1'b0 || scr8 !== 1'b0 || lk8 !== 1'b0) begin
      n_err++; $display("FAIL rd_c123_flags: got ram_cs=%b rom_cs=%b scr=%b lk=%b want 1 0 0 0", mcs8, rcs8, scr8, lk8); end
    n_cmp++; if (bd8 !== ram_q || oe8 !== 1'b1) begin n_err++; $display("FAIL rd_c123_data: got %h want %h", bd8, ram_q); end
    @(negedge clk_cpu);
    idle();
  endtask

  task automatic test_paging();
    page_write(16'h7FFD, 8'h17, 3);
    drive(3'b101, 16'hC000, 8'h00);
    #1;
    n_cmp++; if (a8 !== 17'h1C000 || a32 !== 19'h1C000) begin n_err++; $display("FAIL page7_addr: got %h/%h want 1c000", a8, a32); end
    n_cmp++; if (scr32 !== 1'b0 || scr8 !== 1'b0) begin n_err++; $display("FAIL page7_screen: got %b/%b want 0", scr8, scr32); end
    @(negedge clk_cpu);
    drive(3'b101, 16'h0100, 8'h00);
    #1;
    n_cmp++; if (rcs32 !== 1'b1 || mcs32 !== 1'b0) begin n_err++; $display("FAIL rom_rd_cs: got rom=%b ram=%b want 1 0", rcs32, mcs32); end
    n_cmp++; if (a32 !== 19'h04100) begin n_err++; $display("FAIL rom_bank1_addr32: got %h want 04100", a32); end
    n_cmp++; if (a8 !== 17'h00100) begin n_err++; $display("FAIL rom_single_addr8: got %h want 00100", a8); end
    n_cmp++; if (bd32 !== rom_q) begin n_err++; $display("FAIL rom_rd_data: got %h want %h", bd32, rom_q); end
    @(negedge clk_cpu);
    idle();
  endtask

  task automatic test_lock();
    page_write(16'h7FFD, 8'h20, 1);
    n_cmp++; if (lk8 !== 1'b1 || lk32 !== 1'b1) begin n_err++; $display("FAIL lock_set: got %b/%b want 1", lk8, lk32); end
    page_write(16'h7FFD, 8'h0B, 1);
    drive(3'b101, 16'hC000, 8'h00);
    #1;
    n_cmp++; if (a32 !== 19'(exp_addr(32, 2, 16'hC000)) || a32 !== 19'h00000) begin
      n_err++; $display("FAIL locked_write_ignored: got %h want 00000", a32); end
    n_cmp++; if (scr8 !== 1'b0) begin n_err++; $display("FAIL locked_screen: got %b want 0", scr8); end
    pulse_reset();
    #1;
    n_cmp++; if (lk8 !== 1'b0 || lk32 !== 1'b0) begin n_err++; $display("FAIL unlock_after_reset: got %b/%b want 0", lk8, lk32); end
    idle();
  endtask

  task automatic test_bank32();
    page_write(16'h7FFD, 8'hC5, 1);
    drive(3'b101, 16'hC000, 8'h00);
    #1;
    n_cmp++; if (a32 !== 19'h74000) begin n_err++; $display("FAIL bank29_addr32: got %h want 74000", a32); end
    n_cmp++; if (a8 !== 17'h14000) begin n_err++; $display("FAIL bank5_addr8: got %h want 14000", a8); end
    @(negedge clk_cpu);
    idle();
  endtask

  task automatic test_mem_write();
    @(negedge clk_cpu);
    drive(3'b110, 16'h2000, 8'h5A);
    #1;
    n_cmp++; if (we32 !== 1'b0 || we8 !== 1'b0 || rcs32 !== 1'b1 || mcs32 !== 1'b0) begin
      n_err++; $display("FAIL rom_write: got we=%b rom_cs=%b ram_cs=%b want 0 1 0", we32, rcs32, mcs32); end
    n_cmp++; if (bd32 !== 8'hFF || oe32 !== 1'b0) begin n_err++; $display("FAIL write_no_oe: got %h/%b want ff/0", bd32, oe32); end
    @(negedge clk_cpu);
    drive(3'b110, 16'h8000, 8'hA5);
    #1;
    n_cmp++; if (we32 !== 1'b1 || mcs32 !== 1'b1) begin n_err++; $display("FAIL ram_write: got we=%b cs=%b want 1 1", we32, mcs32); end
    n_cmp++; if (a32 !== 19'h08000 || a8 !== 17'h08000) begin n_err++; $display("FAIL bank2_addr: got %h/%h want 08000", a8, a32); end
    @(negedge clk_cpu);
    idle();
  endtask

  task automatic test_reset_midwrite();
    @(negedge clk_cpu);
    drive(3'b010, 16'h3FFD, 8'h1E);
    @(posedge clk_cpu);
    model_write(16'h3FFD, 8'h1E);
    #1;
    n_cmp++; if (scr32 !== 1'b1 || a32 !== 19'h07FFD) begin n_err++; $display("FAIL midwrite_update: got %b/%h want 1/07ffd", scr32, a32); end
    #2;
    reset = 1'b1;
    m_pg = 8'h00; m_lock = 1'b0;
    #1;
    n_cmp++; if (scr32 !== 1'b0 || a32 !== 19'h03FFD) begin n_err++; $display("FAIL async_reset_clear: got %b/%h want 0/03ffd", scr32, a32); end
    @(negedge clk_cpu);
    reset = 1'b0;
    @(posedge clk_cpu);
    model_write(16'h3FFD, 8'h1E);
    #1;
    n_cmp++; if (scr32 !== 1'b1 || a32 !== 19'h07FFD) begin n_err++; $display("FAIL write_after_reset: got %b/%h want 1/07ffd", scr32, a32); end
    @(negedge clk_cpu);
    idle();
  endtask

`ifdef ZX_KEMPSTON_EN
  task automatic test_kempston();
    int  len;
    bit  bad;
    @(negedge clk_cpu);
    drive(3'b001, 16'h001F, 8'h00);
    kempston = 5'h0F;
    repeat (65) @(posedge clk_cpu);
    #1;
    n_cmp++; if (bd32 !== 8'h00) begin n_err++; $display("FAIL joy_before_latency: got %h want 00", bd32); end
    @(posedge clk_cpu);
    #1;
    n_cmp++; if (bd32 !== 8'h10) begin n_err++; $display("FAIL joy_at_latency: got %h want 10", bd32); end
    repeat (34) @(posedge clk_cpu);
    #1;
    n_cmp++; if (bd8 !== 8'h10 || oe8 !== 1'b1) begin n_err++; $display("FAIL joy_fire_100: got %h want 10", bd8); end
    @(negedge clk_cpu);
    kempston = 5'h1F;
    repeat (70) @(posedge clk_cpu);
    #1;
    n_cmp++; if (bd32 !== 8'h00) begin n_err++; $display("FAIL joy_release: got %h want 00", bd32); end
    for (int g = 0; g < 2; g++) begin
      len = (g == 0) ? 30 : int'($urandom_range(1, 63));
      bad = 1'b0;
      @(negedge clk_cpu);
      kempston = 5'h17;
      repeat (len) begin
        @(negedge clk_cpu);
        if (bd32 !== 8'h00) bad = 1'b1;
      end
      kempston = 5'h1F;
      repeat (80) begin
        @(negedge clk_cpu);
        if (bd32 !== 8'h00) bad = 1'b1;
      end
      n_cmp++; if (bad) begin n_err++; $display("FAIL joy_glitch_len%0d: got visible want 00", len); end
    end
    drive(3'b001, 16'h00FE, 8'h00);
    #1;
    n_cmp++; if (bd32 !== ula_data) begin n_err++; $display("FAIL ula_read: got %h want %h", bd32, ula_data); end
    @(negedge clk_cpu);
    idle();
  endtask
`else
  task automatic test_kempston();
    @(negedge clk_cpu);
    kempston = 5'h00;
    drive(3'b001, 16'h001F, 8'h00);
    repeat (3) @(posedge clk_cpu);
    #1;
    n_cmp++; if (bd32 !== ula_data || oe32 !== 1'b1) begin n_err++; $display("FAIL port1f_ula: got %h want %h", bd32, ula_data); end
    @(negedge clk_cpu);
    kempston = 5'h1F;
    idle();
  endtask
`endif

  task automatic test_random();
    int          op;
    logic [15:0] addr;
    logic [7:0]  data, e_bd;
    bit          e_oe, e_rcs, e_mcs, e_we, cond;
    pulse_reset();
    for (int it = 0; it < 400; it++) begin
      op   = int'($urandom_range(0, 4));
      addr = 16'($urandom);
      data = 8'($urandom);
      if ($urandom_range(0, 9) != 0) data[5] = 1'b0;
      if (op == 3 && $urandom_range(0, 2) != 0) addr = addr & ~16'h8002;
      if (op == 2 && $urandom_range(0, 3) == 0) addr[7:0] = 8'h1F;
      @(negedge clk_cpu);
      case (op)
        0: drive(3'b101, addr, data);
        1: drive(3'b110, addr, data);
        2: drive(3'b001, addr, data);
        3: drive(3'b010, addr, data);
        default: begin drive(3'b111, addr, data); end
      endcase
      #1;
      e_rcs = (op < 2) && (addr[15:14] == 2'd0);
      e_mcs = (op < 2) && (addr[15:14] != 2'd0);
      e_we  = (op == 1) && (addr[15:14] != 2'd0);
      e_oe  = (op == 0) || (op == 2);
      e_bd  = 8'hFF;
      if (op == 0) e_bd = (addr[15:14] == 2'd0) ? rom_q : ram_q;
      if (op == 2) e_bd = ula_data;
`ifdef ZX_KEMPSTON_EN
      if (op == 2 && addr[7:0] == 8'h1F) e_bd = 8'h00;
`endif
      n_cmp++; if ({15'b0, a8} !== 32'(exp_addr(8, 1, addr))) begin
        n_err++; $display("FAIL rnd%0d_addr8: got %h want %h", it, a8, exp_addr(8, 1, addr)); end
      n_cmp++; if ({13'b0, a32} !== 32'(exp_addr(32, 2, addr))) begin
        n_err++; $display("FAIL rnd%0d_addr32: got %h want %h", it, a32, exp_addr(32, 2, addr)); end
      n_cmp++; if ({rcs8, mcs8, we8, rcs32, mcs32, we32} !== {e_rcs, e_mcs, e_we, e_rcs, e_mcs, e_we}) begin
        n_err++; $display("FAIL rnd%0d_selects: got %b%b%b/%b%b%b want %b%b%b", it, rcs8, mcs8, we8, rcs32, mcs32, we32, e_rcs, e_mcs, e_we); end
      n_cmp++; if (bd8 !== e_bd || bd32 !== e_bd || oe8 !== e_oe || oe32 !== e_oe) begin
        n_err++; $display("FAIL rnd%0d_bus: got %h/%h oe %b/%b want %h oe %b", it, bd8, bd32, oe8, oe32, e_bd, e_oe); end
      n_cmp++; if (scr8 !== m_pg[3] || scr32 !== m_pg[3] || lk8 !== m_lock || lk32 !== m_lock) begin
        n_err++; $display("FAIL rnd%0d_state: got scr %b/%b lk %b/%b want %b %b", it, scr8, scr32, lk8, lk32, m_pg[3], m_lock); end
      @(posedge clk_cpu);
      cond = (op == 3) && is_page_port(addr);
      if (cond && !m_prev) model_write(addr, data);
      m_prev = cond;
    end
    @(negedge clk_cpu);
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    A = 16'h0000; D_in = 8'h00; rom_q = 8'h00; ram_q = 8'h00; ula_data = 8'h00;
    kempston = 5'h1F;
    m_pg = 8'h00; m_lock = 1'b0; m_prev = 1'b0;
    test_reset();
    test_paging();
    test_lock();
    test_bank32();
    test_mem_write();
    test_reset_midwrite();
    test_kempston();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
